// File: rtl/core_mem_arbiter.sv
// Shares one 64-bit memory port between instruction fetch (imem) and load/store (dmem).
// Define CORE_MEM_ARB_STARVE_GUARD_EN to compile in the fetch starvation guard.
module core_mem_arbiter #(
    parameter int unsigned            MEM_ADDR_W       = 64,
    parameter int unsigned            STARVE_LIMIT     = 8,
    parameter logic [MEM_ADDR_W-1:0]  PC_RESET_ADDRESS = MEM_ADDR_W'(64'h8000_0000)
) (
    input  logic                  g_clk,
    input  logic                  g_reset,

    input  logic                  imem_req,
    input  logic [MEM_ADDR_W-1:0] imem_addr,
    output logic                  imem_gnt,
    output logic                  imem_err,
    output logic [63:0]           imem_rdata,

    input  logic                  dmem_req,
    input  logic                  dmem_wen,
    input  logic [7:0]            dmem_strb,
    input  logic [MEM_ADDR_W-1:0] dmem_addr,
    input  logic [63:0]           dmem_wdata,
    output logic                  dmem_gnt,
    output logic                  dmem_err,
    output logic [63:0]           dmem_rdata,

    output logic                  mem_req,
    output logic                  mem_wen,
    output logic [7:0]            mem_strb,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [63:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_err,
    input  logic [63:0]           mem_rdata
);

    typedef enum logic [1:0] {StIdle, StLockI, StLockD} arb_state_t;

    arb_state_t            r_state;
    logic                  r_rsp_valid;
    logic                  r_rsp_owner_i;
    logic [MEM_ADDR_W-1:0] r_addr;

    logic                  w_starve;
    logic                  w_sel_i;
    logic                  w_sel_req;

    // A lock pins the owner; in idle dmem wins unless fetch is starving.
    always_comb begin
        w_sel_i = 1'b0;
        case (r_state)
            StLockI: w_sel_i = 1'b1;
            StLockD: w_sel_i = 1'b0;
            default: w_sel_i = imem_req && (!dmem_req || w_starve);
        endcase
    end

    assign w_sel_req = w_sel_i ? imem_req : dmem_req;

    // Requests are held off while reset is applied so no grant loses its response.
    assign mem_req   = w_sel_req && !g_reset;
    assign imem_gnt  = mem_gnt && mem_req && w_sel_i;
    assign dmem_gnt  = mem_gnt && mem_req && !w_sel_i;

    assign mem_addr  = !mem_req ? r_addr : (w_sel_i ? imem_addr : dmem_addr);
    assign mem_wen   = mem_req && !w_sel_i && dmem_wen;
    assign mem_strb  = !mem_req ? 8'h00 : (w_sel_i ? 8'hFF : dmem_strb);
    assign mem_wdata = (mem_req && !w_sel_i) ? dmem_wdata : 64'h0;

    assign imem_rdata = (r_rsp_valid && r_rsp_owner_i)  ? mem_rdata : 64'h0;
    assign imem_err   = r_rsp_valid && r_rsp_owner_i && mem_err;
    assign dmem_rdata = (r_rsp_valid && !r_rsp_owner_i) ? mem_rdata : 64'h0;
    assign dmem_err   = r_rsp_valid && !r_rsp_owner_i && mem_err;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state       <= StIdle;
            r_rsp_valid   <= 1'b0;
            r_rsp_owner_i <= 1'b0;
            r_addr        <= PC_RESET_ADDRESS;
        end else begin
            r_rsp_valid   <= mem_req && mem_gnt;
            r_rsp_owner_i <= w_sel_i;
            if (mem_req) begin
                r_addr <= mem_addr;
            end
            // A lock also releases if its owner abandons the request.
            case (r_state)
                StIdle: begin
                    if (mem_req && !mem_gnt) begin
                        r_state <= w_sel_i ? StLockI : StLockD;
                    end
                end
                StLockI: begin
                    if (mem_gnt || !imem_req) begin
                        r_state <= StIdle;
                    end
                end
                StLockD: begin
                    if (mem_gnt || !dmem_req) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef CORE_MEM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

    logic [7:0] r_starve_cnt;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_starve_cnt <= 8'd0;
        end else if (imem_gnt) begin
            r_starve_cnt <= 8'd0;
        end else if (imem_req && (r_starve_cnt != StarveMax)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    assign w_starve = (r_starve_cnt == StarveMax);
`else
    assign w_starve = 1'b0;
`endif

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares the core's single 64-bit memory port between the instruction fetch requester (`imem_*`) and the load/store requester (`dmem_*`). Picks one requester per cycle and holds that choice until the memory grants it. Routes each one-cycle-delayed response back to the requester that was granted. Sits between the pipeline and the memory bus, directly driving the fetch stage's request/grant/response interface.

## Interface
- `MEM_ADDR_W`, 64, address width in bits.
- `STARVE_LIMIT`, 8, consecutive denied cycles after which fetch gets priority (range 1..255).
- `PC_RESET_ADDRESS`, 64'h80000000, value driven on `mem_addr` while idle after reset.

Ports:
- `g_clk`  in  1  global clock; all state updates on rising edge.
- `g_reset`  in  1  synchronous, active-high reset.
- `imem_req`  in  1  fetch request; held with `imem_addr` until `imem_gnt`.
- `imem_addr`  in  MEM_ADDR_W  fetch address, 8-byte aligned.
- `imem_gnt`  out  1  fetch request accepted this cycle.
- `imem_err`  out  1  fetch response error, valid the cycle after `imem_gnt`.
- `imem_rdata`  out  64  fetch response data, valid the cycle after `imem_gnt`.
- `dmem_req`  in  1  load/store request; held stable until `dmem_gnt`.
- `dmem_wen`  in  1  write enable.
- `dmem_strb`  in  8  byte strobes.
- `dmem_addr`  in  MEM_ADDR_W  load/store address.
- `dmem_wdata`  in  64  write data.
- `dmem_gnt`  out  1  load/store request accepted this cycle.
- `dmem_err`  out  1  load/store response error, valid the cycle after `dmem_gnt`.
- `dmem_rdata`  out  64  load/store read data, valid the cycle after `dmem_gnt`.
- `mem_req`, `mem_wen`, `mem_strb`, `mem_addr`, `mem_wdata`  out  1/1/8/MEM_ADDR_W/64  shared memory request.
- `mem_gnt`  in  1  memory accepted the request.
- `mem_err`, `mem_rdata`  in  1/64  memory response, valid one cycle after `mem_gnt`.

## Operation
- **State machine** `arb_state`: IDLE, LOCK_I, LOCK_D.
  - In IDLE, selection is combinational. `dmem_req` wins, unless `starve` is set and `imem_req` is high; then imem wins. A lone request is selected directly.
  - If the selected request is not granted (`mem_req && !mem_gnt`), the next state is LOCK_I or LOCK_D. The lock holds the selection regardless of the other requester.
  - LOCK_x returns to IDLE on `mem_gnt`, or when the owner drops its req. Dropping req is a protocol violation, but the lock must still release.
- **Mux and grant**:
  - `mem_req` is the req of the selected requester. Address, wen, strb and wdata are muxed from the same requester.
  - When imem is selected: `mem_wen=0` and `mem_strb=8'hFF`.
  - `x_gnt = mem_gnt && selected==x`. It is never asserted for both requesters.
- **Response routing**:
  - Registers `rsp_valid <= mem_req && mem_gnt` and `rsp_owner <= selected`.
  - `x_rdata = (rsp_valid && rsp_owner==x) ? mem_rdata : 0`. `x_err` is gated the same way.
- **Pipelining**: a new grant may occur in the same cycle as the response to the previous grant. Back-to-back grants give one response per cycle.
- **Idle values**: with no request, `mem_addr` holds its last value (`PC_RESET_ADDRESS` after reset), `mem_wdata=0`, `mem_strb=0`.

## Timing
- Request to `mem_req`: 0 cycles. `mem_gnt` to `x_gnt`: 0 cycles. Response: `x_gnt` in cycle N gives data/err in cycle N+1.
- Reset values:
  - `mem_req`, `imem_gnt`, `dmem_gnt`, `imem_err`, `dmem_err` = 0.
  - `imem_rdata`, `dmem_rdata` = 0.
  - `arb_state` = IDLE, `rsp_valid` = 0, `starve_cnt` = 0.
- Reset mid-transaction: the lock and `rsp_valid` clear on the next edge. A response arriving the cycle after reset is dropped (outputs stay 0).
- Simultaneous requests while locked: the non-owner is denied until the lock releases. It may be selected in the cycle after the grant.

## Configuration
- The fetch starvation guard is compiled in by `CORE_MEM_ARB_STARVE_GUARD_EN`.
- **Defined**:
  - 8-bit `starve_cnt` increments each cycle `imem_req && !imem_gnt`, saturating at `STARVE_LIMIT`.
  - It clears on `imem_gnt`.
  - `starve = (starve_cnt == STARVE_LIMIT)`.
- **Undefined**: `starve` is constant 0, giving strict dmem priority with no counter logic.

## Test plan
- **Lone fetch**: `imem_req=1`, `imem_addr=0x80000000`, `mem_gnt=1` → `imem_gnt=1`, `mem_wen=0`, `mem_strb=FF`. Next cycle `mem_rdata=0x1122334455667788` → `imem_rdata` equals it and `dmem_rdata=0`.
- **Contention**: both req in IDLE with `mem_gnt=1` → `dmem_gnt=1`, `imem_gnt=0`. Fetch is granted the following cycle.
- **Lock**: imem selected, `mem_gnt=0` for 3 cycles while `dmem_req` rises in cycle 1 → `mem_addr` stays `imem_addr` and `dmem_gnt` stays 0 until imem is granted.
- **Starvation** (macro on, `STARVE_LIMIT=8`): dmem requests continuously with both reqs high → imem is granted on the 9th cycle. Macro off → imem is never granted.
- **Error routing**: dmem granted with `mem_err=1` next cycle → `dmem_err=1`, `imem_err=0`.
- **Reset mid-lock**: `g_reset=1` while in LOCK_D → next cycle `mem_req=0` (all reqs low), state IDLE, and no response is forwarded.
